// File: rtl/rx_parity_if.sv
// Frame/result bundle between the receive shift register and the parity checker.
// The master drives the frame and mode; the slave returns the registered data byte and check flag.
interface rx_parity_if;
    logic [1:0]  i_Parity;
    logic [10:0] i_Data;
    logic [7:0]  o_Data;
    logic        o_ParityOK;

    modport master (
        output i_Parity,
        output i_Data,
        input  o_Data,
        input  o_ParityOK
    );

    modport slave (
        input  i_Parity,
        input  i_Data,
        output o_Data,
        output o_ParityOK
    );
endinterface

// File: rtl/rx_parity.sv
// Receive-side parity checker: extracts the data byte from an 11-bit frame
// and registers it together with the parity verdict for the configured mode.
module rx_parity (
    input  logic        i_Pclk,
    input  logic        i_Reset,
    rx_parity_if.slave  rx_io
);

    typedef enum logic [1:0] {
        ParNone     = 2'b00,
        ParEven     = 2'b01,
        ParOdd      = 2'b10,
        ParReserved = 2'b11
    } parity_mode_e;

    logic [7:0] data_d, data_q;
    logic       parity_ok_d, parity_ok_q;
    logic       data_xor;
    logic       par_bit;

    // Start (bit 0) and stop (bit 10) are framing concerns and deliberately unused.
    always_comb begin
        data_d      = rx_io.i_Data[8:1];
        data_xor    = ^rx_io.i_Data[8:1];
        par_bit     = rx_io.i_Data[9];
        parity_ok_d = 1'b1;
        unique case (parity_mode_e'(rx_io.i_Parity))
            ParEven:     parity_ok_d = ~(data_xor ^ par_bit);
            ParOdd:      parity_ok_d = data_xor ^ par_bit;
            ParNone:     parity_ok_d = 1'b1;
            ParReserved: parity_ok_d = 1'b1;
            default:     parity_ok_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_Pclk or posedge i_Reset) begin
        if (i_Reset) begin
            data_q      <= 8'h00;
            parity_ok_q <= 1'b0;
        end else begin
            data_q      <= data_d;
            parity_ok_q <= parity_ok_d;
        end
    end

    assign rx_io.o_Data     = data_q;
    assign rx_io.o_ParityOK = parity_ok_q;

endmodule

// File: tb/tb_rx_parity.sv
// Directed bench for rx_parity: hand-computed frames across all parity modes,
// async reset behaviour and framing-bit independence.
module tb_rx_parity;

    logic i_Pclk;
    logic i_Reset;
    int   checks;
    int   errors;

    rx_parity_if rx_bus ();

    rx_parity dut (
        .i_Pclk  (i_Pclk),
        .i_Reset (i_Reset),
        .rx_io   (rx_bus.slave)
    );

    initial i_Pclk = 1'b0;
    always #5 i_Pclk = ~i_Pclk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive away from the edge, then sample 1 time unit after the next rising edge.
    task automatic apply(input logic [1:0] mode, input logic [10:0] frame);
        @(negedge i_Pclk);
        rx_bus.i_Parity = mode;
        rx_bus.i_Data   = frame;
        @(posedge i_Pclk);
        #1;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        i_Reset         = 1'b0;
        rx_bus.i_Parity = 2'b01;
        rx_bus.i_Data   = 11'b10001101010;

        // Load a frame so the registers hold non-reset values.
        apply(2'b01, 11'b10001101010);
        check("preload_data", rx_bus.o_Data, 8'h35);
        check("preload_ok", {7'd0, rx_bus.o_ParityOK}, 8'd1);

        // Asynchronous reset, mid-cycle with no clock edge in between.
        #2;
        i_Reset       = 1'b1;
        rx_bus.i_Data = 11'b11111111111;
        #1;
        check("async_rst_data", rx_bus.o_Data, 8'h00);
        check("async_rst_ok", {7'd0, rx_bus.o_ParityOK}, 8'd0);
        @(posedge i_Pclk);
        #1;
        check("held_rst_data", rx_bus.o_Data, 8'h00);
        check("held_rst_ok", {7'd0, rx_bus.o_ParityOK}, 8'd0);

        @(negedge i_Pclk);
        i_Reset = 1'b0;
        #1;
        check("post_rst_noedge", rx_bus.o_Data, 8'h00);

        apply(2'b01, 11'b10001101010);
        check("even_good_data", rx_bus.o_Data, 8'h35);
        check("even_good_ok", {7'd0, rx_bus.o_ParityOK}, 8'd1);

        apply(2'b01, 11'b11001101010);
        check("even_bad_data", rx_bus.o_Data, 8'h35);
        check("even_bad_ok", {7'd0, rx_bus.o_ParityOK}, 8'd0);

        apply(2'b10, 11'b10001101000);
        check("odd_good_data", rx_bus.o_Data, 8'h34);
        check("odd_good_ok", {7'd0, rx_bus.o_ParityOK}, 8'd1);

        apply(2'b10, 11'b11001101000);
        check("odd_bad_data", rx_bus.o_Data, 8'h34);
        check("odd_bad_ok", {7'd0, rx_bus.o_ParityOK}, 8'd0);

        apply(2'b00, 11'b11001101010);
        check("none_data", rx_bus.o_Data, 8'h35);
        check("none_ok", {7'd0, rx_bus.o_ParityOK}, 8'd1);

        apply(2'b11, 11'b11001101010);
        check("reserved_data", rx_bus.o_Data, 8'h35);
        check("reserved_ok", {7'd0, rx_bus.o_ParityOK}, 8'd1);

        // Same frame, mode switched back to even: verdict recomputed, no sticky state.
        apply(2'b01, 11'b11001101010);
        check("mode_switch_ok", {7'd0, rx_bus.o_ParityOK}, 8'd0);

        // Start=1, stop=0, data 0x35, parity 0, even mode.
        apply(2'b01, 11'b00001101011);
        check("framing_data", rx_bus.o_Data, 8'h35);
        check("framing_ok", {7'd0, rx_bus.o_ParityOK}, 8'd1);

        // Start=1, stop=0 with a wrong even parity bit: framing bits must not mask it.
        apply(2'b01, 11'b01001101011);
        check("framing_bad_ok", {7'd0, rx_bus.o_ParityOK}, 8'd0);

        apply(2'b01, 11'b10000000000);
        check("zero_data", rx_bus.o_Data, 8'h00);
        check("zero_even_ok", {7'd0, rx_bus.o_ParityOK}, 8'd1);

        apply(2'b10, 11'b11111111110);
        check("ff_data", rx_bus.o_Data, 8'hFF);
        check("ff_odd_ok", {7'd0, rx_bus.o_ParityOK}, 8'd1);

        apply(2'b10, 11'b10111111110);
        check("ff_odd_bad_ok", {7'd0, rx_bus.o_ParityOK}, 8'd0);

        // Data LSB mapping: only bit1 set -> 0x01, one '1' plus parity 1 is even-correct.
        apply(2'b01, 11'b11000000010);
        check("lsb_data", rx_bus.o_Data, 8'h01);
        check("lsb_even_ok", {7'd0, rx_bus.o_ParityOK}, 8'd1);

        // Data MSB mapping: only bit8 set -> 0x80.
        apply(2'b00, 11'b00100000000);
        check("msb_data", rx_bus.o_Data, 8'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
